// File: rtl/cla_nibble_seq.sv
// ============================================================================
// Module   : cla_nibble_seq
// Brief    : Multi-cycle adder that reuses one 4-bit carry-lookahead slice,
//            LSB nibble first, with valid/ready on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int c_nibbles = WIDTH / 4;
    localparam int c_cnt_w   = (c_nibbles > 1) ? $clog2(c_nibbles) : 1;
    localparam logic [c_cnt_w-1:0] c_last_nib = c_cnt_w'(c_nibbles - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;
    logic               r_ovf;
    logic               r_done_valid;
    logic               r_busy;
    logic               r_start_ready;

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic [3:0] w_sum;

    // Select the operand nibbles addressed by the current slice index.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < c_nibbles; k++) begin
            if (r_cnt == c_cnt_w'(k)) begin
                w_a = r_a[4*k +: 4];
                w_b = r_b[4*k +: 4];
            end
        end
    end

    assign w_g = w_a & w_b;
    assign w_p = w_a ^ w_b;

    // Every carry is a flat sum of products of g/p and the slice carry-in.
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);

    assign w_sum = w_p ^ w_c[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_a           <= '0;
            r_b           <= '0;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_s           <= '0;
            r_co          <= 1'b0;
            r_ovf         <= 1'b0;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start_valid) begin
                        r_a           <= A_in;
                        r_b           <= B_in;
                        r_carry       <= C_in;
                        r_cnt         <= '0;
                        r_s           <= '0;
                        r_co          <= 1'b0;
                        r_ovf         <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= c_st_run;
                    end
                end
                c_st_run: begin
                    for (int k = 0; k < c_nibbles; k++) begin
                        if (r_cnt == c_cnt_w'(k)) begin
                            r_s[4*k +: 4] <= w_sum;
                        end
                    end
                    r_carry <= w_c[4];
                    // The counter stops on the last nibble; accept reloads it.
                    if (r_cnt == c_last_nib) begin
                        r_co         <= w_c[4];
                        r_ovf        <= w_c[3] ^ w_c[4];
                        r_done_valid <= 1'b1;
                        r_state      <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    if (done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= c_st_idle;
                    end
                end
                default: begin
                    r_done_valid  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= c_st_idle;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign done_valid  = r_done_valid;
    assign S           = r_s;
    assign CO          = r_co;
    assign OVF         = r_ovf;

endmodule

`default_nettype wire
